if_fetch_queue_stage: RTL and testbench
=======================================

Name: if_fetch_queue_stage

Overview:
- Next-generation instruction fetch stage.
- Decouples PC generation from decode through a parametrised fetch queue (FQ) with valid/ready handshake toward ID.
- Drives an external synchronous, word-addressed instruction memory with 1-cycle read latency.
- Accepts redirects from ID/EX (branch, jump, mispredict) that squash in-flight reads and flush the queue.

Parameters:
- BUS_WIDTH, 64: PC width in bits, byte-addressed.
- INSTR_WIDTH, 32: instruction width in bits.
- INSTR_MEM_LEN, 15: instruction memory word-address width.
- FQ_DEPTH, 4: fetch queue entries. Must be a power of 2 and at least 2.
- RESET_PC, 0: byte PC loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  redirect fetch this cycle.
- redirect_pc  in  BUS_WIDTH  new byte PC. Bits [1:0] are ignored and treated as 0.
- imem_en  out  1  read strobe to instruction memory.
- imem_addr  out  INSTR_MEM_LEN  word address, equal to fetch_pc[INSTR_MEM_LEN+1:2].
- imem_rdata  in  INSTR_WIDTH  read data, valid the cycle after imem_en.
- out_valid  out  1  FQ head valid.
- out_ready  in  1  ID accepts the head.
- out_pc  out  BUS_WIDTH  byte PC of the head instruction.
- out_instr  out  INSTR_WIDTH  head instruction.
- fq_count  out  $clog2(FQ_DEPTH)+1  current occupancy, for debug and perf.

Behaviour:
- State:
  - fetch_pc: next byte PC to issue.
  - inflight (1 bit) plus inflight_pc: an issued read whose data returns next cycle.
  - Circular FQ with rd/wr pointers and count. Each entry is {pc, instr}.
- Reset (rst=1): fetch_pc=RESET_PC, inflight=0, count=0, pointers=0, out_valid=0, imem_en=0, fq_count=0. Reset mid-operation discards all queue contents and any in-flight read.
- pop = out_valid & out_ready & ~redirect_valid.
- Issue condition: issue = ~rst & ~redirect_valid & (count + inflight − pop < FQ_DEPTH).
  - Evaluate with widths of at least $clog2(FQ_DEPTH)+2 so there is no underflow.
  - imem_en = issue.
  - On issue: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4.
  - Otherwise inflight <= 0.
- Push: when inflight=1 and no redirect this cycle, write {inflight_pc, imem_rdata} at wr_ptr and advance wr_ptr.
- Pop: advance rd_ptr. Push and pop in the same cycle leave count unchanged.
- The issue condition guarantees no overflow. Asserting push while full is a bug; the bench checks this with an assertion.
- out_valid = (count != 0). out_pc and out_instr are driven combinationally from the entry at rd_ptr.
- Handshake: out_pc and out_instr stay stable while out_valid=1 and out_ready=0. No bypass from memory to output.
- Redirect (cycle N):
  - Count, pointers and inflight clear.
  - Returning imem_rdata is dropped, pop is suppressed, and no issue occurs.
  - fetch_pc <= {redirect_pc[BUS_WIDTH-1:2], 2'b00}.
  - N+1: issue at the redirect PC.
  - N+2: push.
  - N+3: out_valid=1.
- Redirect and rst together: rst wins.
- Throughput: 1 instruction per cycle sustained when out_ready=1 continuously (FQ_DEPTH ≥ 2).
- Back-pressure: with out_ready=0, issue stops once count + inflight reaches FQ_DEPTH. The queue ends full with exactly FQ_DEPTH entries and nothing lost.
- Wrap-around:
  - Pointers wrap modulo FQ_DEPTH.
  - fetch_pc wraps modulo 2^BUS_WIDTH.
  - imem_addr wraps naturally by truncation to INSTR_MEM_LEN bits.

Test Plan:
- Reset then out_ready=1, memory word k returns 0x1000_0000+k:
  - imem_en rises the first cycle after rst falls, with addr 0.
  - out_valid first rises 2 cycles later with pc=0, instr=0x10000000.
  - Then pc=4, 8, 12… every cycle with no bubbles.
- out_ready=0 from reset, FQ_DEPTH=4:
  - Exactly 4 issues (addr 0..3), then imem_en=0.
  - fq_count=4, out_pc holds 0 and stays stable.
  - Raising out_ready drains 0, 4, 8, 12, and issue resumes at addr 4 the cycle the first pop occurs.
- Steady stream, redirect_valid=1 with redirect_pc=0x203 at cycle N:
  - out_valid=0 in N+1 and N+2, imem_addr=0x80 in N+1.
  - In N+3 out_valid=1 with out_pc=0x200, and no stale pre-redirect instruction ever appears.
- Redirect while queue full with out_ready=1 in the same cycle: no pop is counted, fq_count=0 next cycle, resumes at the target.
- Assert rst for 1 cycle mid-stream with 3 entries queued: all outputs return to reset values and fetch restarts at RESET_PC.
- FQ_DEPTH=2, random out_ready (50%), 1000 cycles with random redirects:
  - Scoreboard confirms in-order PCs matching the memory model.
  - No overflow assertion fires, and instructions are never duplicated or dropped between redirects.

Source files
------------

// File: rtl/if_fetch_queue_stage.sv
// Instruction fetch stage with a decoupling fetch queue.
//
// PC generation issues one word read per cycle to a synchronous instruction memory
// (1-cycle read latency). Returned words are tagged with their PC and pushed into a
// circular fetch queue that ID drains through a valid/ready handshake. A redirect
// squashes the in-flight read, flushes the queue and restarts fetch at the new PC.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   redirect_valid   redirect fetch this cycle (branch/jump/mispredict)
//   redirect_pc      new byte PC, bits [1:0] ignored
//   imem_en          read strobe to instruction memory
//   imem_addr        word address of the read (fetch_pc[INSTR_MEM_LEN+1:2])
//   imem_rdata       read data, valid the cycle after imem_en
//   out_valid        queue head valid
//   out_ready        ID accepts the head
//   out_pc           byte PC of the head instruction
//   out_instr        head instruction
//   fq_count         current queue occupancy
//
// FQ_DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module if_fetch_queue_stage #(
    parameter int unsigned          BUS_WIDTH     = 64,
    parameter int unsigned          INSTR_WIDTH   = 32,
    parameter int unsigned          INSTR_MEM_LEN = 15,
    parameter int unsigned          FQ_DEPTH      = 4,
    parameter logic [BUS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [BUS_WIDTH-1:0]       redirect_pc,
    output logic                       imem_en,
    output logic [INSTR_MEM_LEN-1:0]   imem_addr,
    input  logic [INSTR_WIDTH-1:0]     imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BUS_WIDTH-1:0]       out_pc,
    output logic [INSTR_WIDTH-1:0]     out_instr,
    output logic [$clog2(FQ_DEPTH):0]  fq_count
);

    localparam int unsigned PtrW  = $clog2(FQ_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    // One extra bit so count + inflight never overflows before the compare.
    localparam int unsigned CalcW = PtrW + 2;

    logic [BUS_WIDTH-1:0]   fetch_pc_q;
    logic                   inflight_q;
    logic [BUS_WIDTH-1:0]   inflight_pc_q;
    logic [PtrW-1:0]        rd_ptr_q;
    logic [PtrW-1:0]        wr_ptr_q;
    logic [CntW-1:0]        count_q;
    logic [CntW-1:0]        count_d;

    logic [BUS_WIDTH-1:0]   fq_pc    [FQ_DEPTH];
    logic [INSTR_WIDTH-1:0] fq_instr [FQ_DEPTH];

    logic                   pop;
    logic                   push;
    logic                   issue;
    logic [CalcW-1:0]       occ_after_pop;

    // Low PC bits of a redirect are forced to zero.
    logic                   unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign out_valid = (count_q != '0);
    assign out_pc    = fq_pc[rd_ptr_q];
    assign out_instr = fq_instr[rd_ptr_q];
    assign fq_count  = count_q;
    assign imem_en   = issue;
    assign imem_addr = fetch_pc_q[INSTR_MEM_LEN+1:2];

    always_comb begin
        pop  = out_valid & out_ready & ~redirect_valid;
        push = inflight_q & ~redirect_valid;
        // Reserve a slot for every read already in flight, but free the one popped now.
        occ_after_pop = CalcW'(count_q) + CalcW'(inflight_q) - CalcW'(pop);
        issue = ~rst & ~redirect_valid & (occ_after_pop < CalcW'(FQ_DEPTH));

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else if (redirect_valid) begin
            fetch_pc_q <= {redirect_pc[BUS_WIDTH-1:2], 2'b00};
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= fetch_pc_q;
                fetch_pc_q    <= fetch_pc_q + BUS_WIDTH'(4);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    // Queue storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fq_pc[wr_ptr_q]    <= inflight_pc_q;
            fq_instr[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue_stage.sv
// Bench for if_fetch_queue_stage: two instances (FQ_DEPTH 4 and 2) share one stimulus
// stream. A queue-based reference model predicts every output each cycle; directed
// scenarios add fixed expectations on the depth-4 instance.
module tb_if_fetch_queue_stage;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_ready = 1'b0;

    logic [1:0]  en_w;
    logic [1:0]  valid_w;
    logic [14:0] addr_w  [2];
    logic [63:0] pc_w    [2];
    logic [31:0] instr_w [2];
    logic [31:0] rdata   [2];
    logic [2:0]  cnt4;
    logic [1:0]  cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance.
    logic [63:0] m_fpc  [2];
    logic [63:0] m_ipc  [2];
    bit          m_infl [2];
    logic [95:0] m_q    [2][$];

    always #5 clk = ~clk;

    if_fetch_queue_stage #(.FQ_DEPTH(4), .RESET_PC(RESET_PC)) u_dut4 (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (en_w[0]),
        .imem_addr      (addr_w[0]),
        .imem_rdata     (rdata[0]),
        .out_valid      (valid_w[0]),
        .out_ready      (out_ready),
        .out_pc         (pc_w[0]),
        .out_instr      (instr_w[0]),
        .fq_count       (cnt4)
    );

    if_fetch_queue_stage #(.FQ_DEPTH(2), .RESET_PC(RESET_PC)) u_dut2 (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (en_w[1]),
        .imem_addr      (addr_w[1]),
        .imem_rdata     (rdata[1]),
        .out_valid      (valid_w[1]),
        .out_ready      (out_ready),
        .out_pc         (pc_w[1]),
        .out_instr      (instr_w[1]),
        .fq_count       (cnt2)
    );

    function automatic logic [31:0] mem_word(input logic [14:0] a);
        return 32'h1000_0000 + {17'b0, a};
    endfunction

    // Synchronous instruction memory, 1-cycle latency.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (en_w[i]) rdata[i] <= mem_word(addr_w[i]);
        end
    end

    always @(negedge clk) begin
        if (!rst) assert (cnt4 <= 3'd4 && cnt2 <= 2'd2) else $error("fq occupancy above depth");
    end

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        int depth;
        int sz;
        bit pop;
        bit issue;
        depth = (i == 0) ? 4 : 2;
        if (rst) begin
            m_fpc[i]  = RESET_PC;
            m_infl[i] = 1'b0;
            m_q[i].delete();
        end else if (redirect_valid) begin
            m_fpc[i]  = {redirect_pc[63:2], 2'b00};
            m_infl[i] = 1'b0;
            m_q[i].delete();
        end else begin
            sz    = m_q[i].size();
            pop   = out_ready && sz != 0;
            issue = (sz + int'(m_infl[i]) - int'(pop)) < depth;
            if (pop) void'(m_q[i].pop_front());
            if (m_infl[i]) begin
                assert (m_q[i].size() < depth) else $error("push into full queue");
                m_q[i].push_back({m_ipc[i], mem_word(m_ipc[i][16:2])});
            end
            if (issue) begin
                m_ipc[i] = m_fpc[i];
                m_fpc[i] = m_fpc[i] + 64'd4;
            end
            m_infl[i] = issue;
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int   depth;
            int   sz;
            bit   pop;
            bit   exp_en;
            logic [2:0] cnt;
            string d;
            depth  = (i == 0) ? 4 : 2;
            d      = (i == 0) ? "d4" : "d2";
            sz     = m_q[i].size();
            pop    = out_ready && sz != 0 && !redirect_valid;
            exp_en = !rst && !redirect_valid && ((sz + int'(m_infl[i]) - int'(pop)) < depth);
            cnt    = (i == 0) ? cnt4 : {1'b0, cnt2};
            check_eq({d, "_count"}, 96'(cnt), 96'(sz));
            check_eq({d, "_valid"}, 96'(valid_w[i]), 96'(sz != 0));
            check_eq({d, "_imem_en"}, 96'(en_w[i]), 96'(exp_en));
            if (sz != 0) check_eq({d, "_head"}, {pc_w[i], instr_w[i]}, m_q[i][0]);
            if (exp_en) check_eq({d, "_addr"}, 96'(addr_w[i]), 96'(m_fpc[i][16:2]));
        end
    endtask

    task automatic cycle(input logic r, input logic rv, input logic [63:0] rpc, input logic rdy);
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 64'h0, 1'b0);
        cycle(1'b1, 1'b0, 64'h0, 1'b0);
    endtask

    initial begin
        int n_iss;

        // Streaming from reset with ID always ready.
        do_reset();
        cycle(1'b0, 1'b0, 64'h0, 1'b1);
        check_eq("s1_first_en", 96'(en_w[0]), 96'(1));
        check_eq("s1_first_addr", 96'(addr_w[0]), 96'(0));
        cycle(1'b0, 1'b0, 64'h0, 1'b1);
        check_eq("s1_bubble", 96'(valid_w[0]), 96'(0));
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 64'h0, 1'b1);
            check_eq("s1_valid", 96'(valid_w[0]), 96'(1));
            check_eq("s1_pc", 96'(pc_w[0]), 96'(4 * k));
            check_eq("s1_instr", 96'(instr_w[0]), 96'(32'h1000_0000 + k));
        end

        // Back-pressure from reset: fill exactly to depth, then drain.
        do_reset();
        n_iss = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 64'h0, 1'b0);
            if (en_w[0]) begin
                check_eq("s2_issue_addr", 96'(addr_w[0]), 96'(n_iss));
                n_iss++;
            end
        end
        check_eq("s2_issue_count", 96'(n_iss), 96'(4));
        check_eq("s2_full", 96'(cnt4), 96'(4));
        check_eq("s2_hold_pc", 96'(pc_w[0]), 96'(0));
        cycle(1'b0, 1'b0, 64'h0, 1'b0);
        check_eq("s2_hold_pc2", 96'(pc_w[0]), 96'(0));
        check_eq("s2_no_issue", 96'(en_w[0]), 96'(0));
        for (int j = 0; j < 4; j++) begin
            cycle(1'b0, 1'b0, 64'h0, 1'b1);
            check_eq("s2_drain_pc", 96'(pc_w[0]), 96'(4 * j));
            if (j == 0) begin
                check_eq("s2_resume_en", 96'(en_w[0]), 96'(1));
                check_eq("s2_resume_addr", 96'(addr_w[0]), 96'(4));
            end
        end

        // Redirect in a steady stream to an unaligned PC.
        do_reset();
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 64'h0, 1'b1);
        cycle(1'b0, 1'b1, 64'h203, 1'b1);
        cycle(1'b0, 1'b0, 64'h0, 1'b1);
        check_eq("s3_n1_valid", 96'(valid_w[0]), 96'(0));
        check_eq("s3_n1_en", 96'(en_w[0]), 96'(1));
        check_eq("s3_n1_addr", 96'(addr_w[0]), 96'(15'h80));
        cycle(1'b0, 1'b0, 64'h0, 1'b1);
        check_eq("s3_n2_valid", 96'(valid_w[0]), 96'(0));
        cycle(1'b0, 1'b0, 64'h0, 1'b1);
        check_eq("s3_n3_valid", 96'(valid_w[0]), 96'(1));
        check_eq("s3_n3_pc", 96'(pc_w[0]), 96'(64'h200));
        check_eq("s3_n3_instr", 96'(instr_w[0]), 96'(32'h1000_0080));

        // Redirect while full with ID ready in the same cycle.
        do_reset();
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 64'h0, 1'b0);
        check_eq("s4_full", 96'(cnt4), 96'(4));
        cycle(1'b0, 1'b1, 64'h1000, 1'b1);
        check_eq("s4_redir_no_issue", 96'(en_w[0]), 96'(0));
        cycle(1'b0, 1'b0, 64'h0, 1'b1);
        check_eq("s4_flushed", 96'(cnt4), 96'(0));
        check_eq("s4_resume_en", 96'(en_w[0]), 96'(1));
        check_eq("s4_resume_addr", 96'(addr_w[0]), 96'(15'h400));
        cycle(1'b0, 1'b0, 64'h0, 1'b1);
        cycle(1'b0, 1'b0, 64'h0, 1'b1);
        check_eq("s4_target_pc", 96'(pc_w[0]), 96'(64'h1000));

        // Reset pulse mid-stream with three entries queued.
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 64'h0, 1'b0);
        cycle(1'b1, 1'b0, 64'h0, 1'b0);
        check_eq("s5_pre_count", 96'(cnt4), 96'(3));
        check_eq("s5_rst_en", 96'(en_w[0]), 96'(0));
        cycle(1'b0, 1'b0, 64'h0, 1'b1);
        check_eq("s5_count", 96'(cnt4), 96'(0));
        check_eq("s5_valid", 96'(valid_w[0]), 96'(0));
        check_eq("s5_restart_en", 96'(en_w[0]), 96'(1));
        check_eq("s5_restart_addr", 96'(addr_w[0]), 96'(0));

        // Random traffic with redirects (including near PC wrap) and rare resets.
        do_reset();
        for (int k = 0; k < 1000; k++) begin
            logic        r;
            logic        rv;
            logic        rdy;
            logic [63:0] rpc;
            r   = ($urandom_range(0, 199) == 0);
            rv  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            cycle(r, rv, rpc, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
